handshake_responder: RTL and testbench

HANDSHAKE_RESPONDER -- requirements
Module: handshake_responder

---
 rtl/handshake_pkg.sv | 12 +
 rtl/mult_step.sv | 14 +
 rtl/handshake_responder.sv | 94 +++++++++
 tb/tb_handshake_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared FSM state encoding and default operand width
package handshake_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - one combinational shift-add multiply step
module mult_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic               mbit,
  output logic [2*WIDTH-1:0] acc_next
);

  // mcand is pre-shifted by the caller, so the sum never exceeds 2*WIDTH bits
  assign acc_next = mbit ? (acc + mcand) : acc;

endmodule

// File: rtl/handshake_responder.sv
// rtl/handshake_responder.sv - start/ready/done responder around an iterative multiplier
module handshake_responder
  import handshake_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic               accept;
  logic               step;
  logic               last;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mbit     (mplier[0]),
    .acc_next (acc_next)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last       = (cnt == LAST_STEP);
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = start && !abort;
        if (accept) state_next = BUSY;
      end
      BUSY: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (last) state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, op_a};
        mplier <= op_b;
        acc    <= '0;
        cnt    <= '0;
      end else if (step) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        // result only moves on a completed job, so an abort leaves the old value
        if (last) result <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_handshake_responder.sv
// tb/tb_handshake_responder.sv - directed self-checking bench for handshake_responder
module tb_handshake_responder;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [WIDTH-1:0]   op_a = '0;
  logic [WIDTH-1:0]   op_b = '0;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  handshake_responder #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .op_a   (op_a),
    .op_b   (op_b),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept a job, then count edges after accept until done is seen
  task automatic run_job(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [15:0] exp);
    int n;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_ready_low"}, ready, 0);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, WIDTH);
    check({tag, "_result"}, result, exp);
    tick();
    check({tag, "_ready_back"}, ready, 1);
    check({tag, "_done_drop"}, done, 0);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int dones;
    int first_done;
    int second_done;

    tick();
    tick();
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);

    // first accept on the first edge after release
    rst = 1'b0;
    run_job("basic", 8'h0C, 8'h0A, 16'h0078);
    run_job("max", 8'hFF, 8'hFF, 16'hFE01);
    run_job("zero", 8'h00, 8'h00, 16'h0000);

    // start held high: accepts only when idle, done pulses 10 edges apart
    op_a = 8'd3;
    op_b = 8'd5;
    start = 1'b1;
    dones = 0;
    first_done = 0;
    second_done = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 2) check("hold_busy_ready", ready, 0);
      if (done) begin
        dones++;
        if (dones == 1) first_done = k;
        if (dones == 2) second_done = k;
        check("hold_result", result, 16'h000F);
      end
    end
    start = 1'b0;
    check("hold_done_count", dones, 2);
    check("hold_first_done", first_done, 9);
    check("hold_done_gap", second_done - first_done, 10);
    tick();

    // operands changing mid-job must not leak in
    op_a = 8'd2;
    op_b = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    op_a = 8'hFF;
    begin
      int n = 2;
      while (!done && n < 40) begin
        tick();
        n++;
      end
      check("opchg_latency", n, WIDTH);
    end
    check("opchg_result", result, 16'h000E);
    tick();

    // abort mid-job keeps the prior result and never pulses done
    run_job("prior", 8'h0C, 8'h0A, 16'h0078);
    op_a = 8'hFF;
    op_b = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_result", result, 16'h0078);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);

    // abort beats start in idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", ready, 1);

    // asynchronous reset mid-job
    op_a = 8'hFF;
    op_b = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    tick();
    rst = 1'b0;
    run_job("postrst", 8'd4, 8'd4, 16'h0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
